// File: rtl/func_sel_pkg.sv
// func_sel_pkg: operation encoding and evaluation function shared by the pipe.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package func_sel_pkg;

    // Widest operand the pipe supports; f_eval works at this width.
    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_ADD = 2'b11
    } op_e;

    // Operands arrive zero-extended from WIDTH to MAX_W bits. For a WIDTH-bit
    // caller, bit WIDTH of the result is the carry out of the add.
    // The upper bits of the logic ops stay zero, so their carry reads as 0.
    function automatic logic [MAX_W:0] f_eval(input op_e op,
                                              input logic [MAX_W-1:0] x,
                                              input logic [MAX_W-1:0] y);
        logic [MAX_W:0] r;
        case (op)
            OP_AND:  r = {1'b0, x & y};
            OP_OR:   r = {1'b0, x | y};
            OP_XOR:  r = {1'b0, x ^ y};
            OP_ADD:  r = {1'b0, x} + {1'b0, y};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/func_sel_stage.sv
// func_sel_stage: one pipeline slot holding valid, result and carry.
// Latency: 1 cycle (registered on i_load).
// Backpressure: holds contents while i_load is low; the parent computes i_load.
// Ports: i_load   - capture upstream slot this edge.
//        i_vld/i_dat/i_cry - upstream valid, result and carry.
//        o_vld/o_dat/o_cry - registered slot contents.
module func_sel_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_cry,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_cry
);

    logic             r_vld;
    logic [WIDTH-1:0] r_dat;
    logic             r_cry;

    // Loading with i_vld low empties the slot; that is how bubbles move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_dat <= '0;
            r_cry <= 1'b0;
        end else if (i_load) begin
            r_vld <= i_vld;
            r_dat <= i_dat;
            r_cry <= i_cry;
        end
    end

    assign o_vld = r_vld;
    assign o_dat = r_dat;
    assign o_cry = r_cry;

endmodule

// File: rtl/func_sel_pipe.sv
// func_sel_pipe: AND/OR/XOR/ADD of a and b, selected by {s1,s0}, through STAGES register slots.
// Latency: STAGES cycles from input handshake to out_valid; 1 beat/cycle throughput.
// Backpressure: per-slot bubble collapse; in_ready is combinational from out_ready and the slot valids.
// Ports: in_valid/in_ready/s1/s0/a/b - operand beat in.
//        out_valid/out_ready/e/cout   - result beat out; cout only set for ADD.
//        done_cnt                     - output handshakes, wrapping.
module func_sel_pipe
    import func_sel_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             s0,
    input  logic             s1,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] e,
    output logic             cout,
    output logic [CNT_W-1:0] done_cnt
);

    logic [MAX_W-1:0] w_a_ext;
    logic [MAX_W-1:0] w_b_ext;
    logic [MAX_W:0]   w_eval;
    logic             w_unused_eval;
    logic [WIDTH-1:0] w_res;
    logic             w_res_cry;

    logic [STAGES-1:0] w_vld;
    logic [STAGES-1:0] w_load;
    logic [WIDTH-1:0]  w_dat [STAGES];
    logic              w_cry [STAGES];

    logic [CNT_W-1:0]  r_done_cnt;

    always_comb begin
        w_a_ext = '0;
        w_b_ext = '0;
        w_a_ext[WIDTH-1:0] = a;
        w_b_ext[WIDTH-1:0] = b;
    end

    assign w_eval    = f_eval(op_e'({s1, s0}), w_a_ext, w_b_ext);
    assign w_res     = w_eval[WIDTH-1:0];
    assign w_res_cry = w_eval[WIDTH];
    // Bits above the carry are always zero for WIDTH < MAX_W.
    assign w_unused_eval = ^w_eval;

    // Ready chain walks from the output back to the input: a slot loads when
    // it is empty or when the slot after it is loading this same edge.
    always_comb begin : p_ready_chain
        logic w_nxt;
        w_load = '0;
        w_nxt  = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_load[k] = !w_vld[k] || w_nxt;
            w_nxt     = w_load[k];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             w_i_vld;
        logic [WIDTH-1:0] w_i_dat;
        logic             w_i_cry;

        if (k == 0) begin : g_head
            assign w_i_vld = in_valid;
            assign w_i_dat = w_res;
            assign w_i_cry = w_res_cry;
        end else begin : g_body
            assign w_i_vld = w_vld[k-1];
            assign w_i_dat = w_dat[k-1];
            assign w_i_cry = w_cry[k-1];
        end

        func_sel_stage #(.WIDTH(WIDTH)) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_load (w_load[k]),
            .i_vld  (w_i_vld),
            .i_dat  (w_i_dat),
            .i_cry  (w_i_cry),
            .o_vld  (w_vld[k]),
            .o_dat  (w_dat[k]),
            .o_cry  (w_cry[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_cnt <= '0;
        end else if (out_valid && out_ready) begin
            r_done_cnt <= r_done_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = w_vld[STAGES-1];
    assign e         = w_dat[STAGES-1];
    assign cout      = w_cry[STAGES-1];
    assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_func_sel_pipe.sv
module tb_func_sel_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    // Main DUT: WIDTH=8, STAGES=2, CNT_W=4
    logic       in_valid, in_ready, s0, s1, out_valid, out_ready, cout;
    logic [7:0] a, b, e;
    logic [3:0] done_cnt;
    // Second DUT: WIDTH=8, STAGES=3, CNT_W=16 (bubble collapse)
    logic        in_valid3, in_ready3, s0_3, s1_3, out_valid3, out_ready3, cout3;
    logic [7:0]  a3, b3, e3;
    logic [15:0] done_cnt3;

    int total = 0;
    int bad   = 0;
    logic [8:0] sb [$];

    always #5 clk = ~clk;

    func_sel_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .s0(s0), .s1(s1), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .e(e), .cout(cout), .done_cnt(done_cnt)
    );

    func_sel_pipe #(.WIDTH(8), .STAGES(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .s0(s0_3), .s1(s1_3), .a(a3), .b(b3), .out_valid(out_valid3), .out_ready(out_ready3),
        .e(e3), .cout(cout3), .done_cnt(done_cnt3)
    );

    function automatic logic [8:0] model(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
        case (op)
            2'b00:   return {1'b0, x & y};
            2'b01:   return {1'b0, x | y};
            2'b10:   return {1'b0, x ^ y};
            default: return {1'b0, x} + {1'b0, y};
        endcase
    endfunction

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected got=%h want=none", {cout, e});
                end else begin
                    logic [8:0] exp_v;
                    exp_v = sb.pop_front();
                    if ({cout, e} !== exp_v) begin
                        bad++;
                        $display("FAIL sb_result got=%h want=%h", {cout, e}, exp_v);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model({s1, s0}, a, b));
        end
    end

    task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
        in_valid = v;
        {s1, s0} = op;
        a = x;
        b = y;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        out_ready = 1'b0;
        in_valid3 = 1'b0; out_ready3 = 1'b0; s0_3 = 1'b0; s1_3 = 1'b0; a3 = '0; b3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (e !== 8'h00) begin bad++; $display("FAIL reset_e got=%h want=00", e); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", cout); end
        total++; if (done_cnt !== 4'd0) begin bad++; $display("FAIL reset_done_cnt got=%0d want=0", done_cnt); end
        next_cyc();
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
        next_cyc();
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        drive(1'b1, 2'b11, 8'h7F, 8'h01);
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lat_accept got=%b want=1", in_ready); end
        next_cyc();   // edge n: beat accepted
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early got=%b want=0", out_valid); end
        next_cyc();   // edge n+1
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_visible got=%b want=1", out_valid); end
        total++; if ({cout, e} !== 9'h080) begin bad++; $display("FAIL lat_data got=%h want=080", {cout, e}); end
        next_cyc();   // output handshake
        @(negedge clk);
        total++; if (done_cnt !== 4'd1) begin bad++; $display("FAIL lat_done_cnt got=%0d want=1", done_cnt); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_drained got=%b want=0", out_valid); end
        next_cyc();
    endtask

    task automatic test_op_sweep();
        logic [7:0] exp_e [4];
        logic       exp_c [4];
        int sent, got;
        exp_e = '{8'h30, 8'hFC, 8'hCC, 8'h2C};
        exp_c = '{1'b0, 1'b0, 1'b0, 1'b1};
        sent = 0; got = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 16 && got < 4; cyc++) begin
            if (sent < 4) drive(1'b1, 2'(sent), 8'hF0, 8'h3C);
            else          drive(1'b0, 2'b00, 8'h00, 8'h00);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                total++;
                if (e !== exp_e[got] || cout !== exp_c[got]) begin
                    bad++;
                    $display("FAIL op_sweep_%0d got=%b/%h want=%b/%h", got, cout, e, exp_c[got], exp_e[got]);
                end
                got++;
            end
            next_cyc();
        end
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        total++; if (got != 4) begin bad++; $display("FAIL op_sweep_count got=%0d want=4", got); end
    endtask

    task automatic test_back_to_back();
        int n_rdy;
        n_rdy = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            @(negedge clk);
            if (in_ready === 1'b1) n_rdy++;
            next_cyc();
        end
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        total++; if (n_rdy != 8) begin bad++; $display("FAIL b2b_in_ready got=%0d want=8", n_rdy); end
        for (int i = 0; i < 10 && (sb.size() != 0 || out_valid); i++) next_cyc();
        @(negedge clk);
        total++; if (sb.size() != 0) begin bad++; $display("FAIL b2b_drain got=%0d want=0", sb.size()); end
        next_cyc();
    endtask

    task automatic test_backpressure();
        int acc;
        logic [7:0] held_e;
        logic       held_c;
        acc = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            @(negedge clk);
            if (in_ready) acc++;
            next_cyc();
        end
        @(negedge clk);
        total++; if (acc != 2) begin bad++; $display("FAIL bp_accepted got=%0d want=2", acc); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid got=%b want=1", out_valid); end
        held_e = e; held_c = cout;
        next_cyc();
        next_cyc();
        @(negedge clk);
        total++; if (e !== held_e || cout !== held_c) begin bad++; $display("FAIL bp_stable got=%b/%h want=%b/%h", cout, e, held_c, held_e); end
        next_cyc();
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_follow got=%b want=1", in_ready); end
        next_cyc();
        for (int i = 0; i < 10 && (sb.size() != 0 || out_valid); i++) next_cyc();
        @(negedge clk);
        total++; if (sb.size() != 0) begin bad++; $display("FAIL bp_drain got=%0d want=0", sb.size()); end
        next_cyc();
    endtask

    task automatic test_mid_reset();
        int stale;
        stale = 0;
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 8'h12, 8'h34);
        next_cyc();
        drive(1'b1, 2'b11, 8'h56, 8'h78);
        next_cyc();
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        rst_n = 1'b0;
        sb.delete();
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_out_valid got=%b want=0", out_valid); end
        total++; if (done_cnt !== 4'd0) begin bad++; $display("FAIL mrst_done_cnt got=%0d want=0", done_cnt); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mrst_in_ready got=%b want=1", in_ready); end
        next_cyc();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
            next_cyc();
        end
        total++; if (stale != 0) begin bad++; $display("FAIL mrst_stale got=%0d want=0", stale); end
    endtask

    task automatic test_wrap();
        int sent, got;
        sent = 0; got = 0;
        rst_n = 1'b0;
        sb.delete();
        next_cyc();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 17; cyc++) begin
            if (sent < 17) drive(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            else           drive(1'b0, 2'b00, 8'h00, 8'h00);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) got++;
            next_cyc();
        end
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        @(negedge clk);
        total++; if (got != 17) begin bad++; $display("FAIL wrap_handshakes got=%0d want=17", got); end
        total++; if (done_cnt !== 4'd1) begin bad++; $display("FAIL wrap_done_cnt got=%0d want=1", done_cnt); end
        next_cyc();
    endtask

    task automatic test_bubble();
        logic [8:0] exp_q [3];
        int got;
        exp_q = '{9'h00F, 9'h011, 9'h100};
        got = 0;
        out_ready3 = 1'b0;
        in_valid3 = 1'b1; {s1_3, s0_3} = 2'b00; a3 = 8'hFF; b3 = 8'h0F;
        @(negedge clk);
        total++; if (in_ready3 !== 1'b1) begin bad++; $display("FAIL bub_beat1 got=%b want=1", in_ready3); end
        next_cyc();
        in_valid3 = 1'b0;
        next_cyc();
        in_valid3 = 1'b1; {s1_3, s0_3} = 2'b01; a3 = 8'h10; b3 = 8'h01;
        @(negedge clk);
        total++; if (in_ready3 !== 1'b1) begin bad++; $display("FAIL bub_beat2 got=%b want=1", in_ready3); end
        next_cyc();
        {s1_3, s0_3} = 2'b11; a3 = 8'h80; b3 = 8'h80;
        @(negedge clk);
        total++; if (in_ready3 !== 1'b1) begin bad++; $display("FAIL bub_beat3 got=%b want=1", in_ready3); end
        next_cyc();
        in_valid3 = 1'b0;
        @(negedge clk);
        total++; if (in_ready3 !== 1'b0) begin bad++; $display("FAIL bub_full got=%b want=0", in_ready3); end
        total++; if (out_valid3 !== 1'b1 || e3 !== 8'h0F) begin bad++; $display("FAIL bub_head got=%b/%h want=1/0f", out_valid3, e3); end
        next_cyc();
        out_ready3 = 1'b1;
        for (int cyc = 0; cyc < 10 && got < 3; cyc++) begin
            @(negedge clk);
            if (out_valid3) begin
                total++;
                if ({cout3, e3} !== exp_q[got]) begin
                    bad++;
                    $display("FAIL bub_out_%0d got=%h want=%h", got, {cout3, e3}, exp_q[got]);
                end
                got++;
            end
            next_cyc();
        end
        @(negedge clk);
        total++; if (got != 3) begin bad++; $display("FAIL bub_count got=%0d want=3", got); end
        total++; if (done_cnt3 !== 16'd3) begin bad++; $display("FAIL bub_done_cnt got=%0d want=3", done_cnt3); end
        next_cyc();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_op_sweep();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_wrap();
        test_bubble();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/func_sel_pipe.md
# func_sel_pipe

Parametrised, pipelined successor to the team's two-select combinational function block. It applies one of four operations, chosen by per-transaction select bits `s1:s0`, to two `WIDTH`-bit operands `a` and `b`. Results pass through `STAGES` register stages with a valid/ready handshake on both sides and per-stage bubble collapsing. The block sits between an operand producer and a result consumer in the lab datapath, and it keeps a count of completed transactions.

## Interface
- `WIDTH`, 8: operand and result width in bits, 1..32.
- `STAGES`, 2: number of pipeline register stages, 1..4.
- `CNT_W`, 16: width of the completed-transaction counter.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  operand beat offered.
- `in_ready`  out  1  block accepts the beat this cycle.
- `s0`  in  1  select bit 0.
- `s1`  in  1  select bit 1.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `out_valid`  out  1  result beat offered.
- `out_ready`  in  1  consumer accepts the result.
- `e`  out  WIDTH  result.
- `cout`  out  1  carry out, valid only for op ADD; 0 for other ops.
- `done_cnt`  out  CNT_W  number of completed output handshakes, wraps modulo 2^CNT_W.

## Operation
- Op code is `{s1,s0}`:
  - 00 AND: `e = a & b`.
  - 01 OR: `e = a | b`.
  - 10 XOR: `e = a ^ b`.
  - 11 ADD: `{cout,e} = a + b`, computed at WIDTH+1 bits, so `e` is the sum modulo 2^WIDTH.
- The function is evaluated combinationally at the input. It is captured into stage 1 together with `cout` and a stage-valid bit.
- Each stage `k` holds `v[k]`, `e[k]` and `c[k]`.
- Stage `k` loads when it is empty or when stage `k+1` loads in the same cycle. For the last stage, the condition is empty or `out_ready`.
- `in_ready` = stage-1 load condition. It is combinational from `out_ready` through the stage chain, with no registered skid.
- Input handshake: `in_valid && in_ready`. A stage that loads with no upstream data becomes empty (`v` = 0).
- Output handshake: `out_valid && out_ready`. `out_valid`, `e` and `cout` are the last-stage registers.
- While `out_valid && !out_ready`, the output is a stall: `e` and `cout` hold stable.
- Bubbles collapse: an empty stage accepts data even while downstream stages are stalled.
- `done_cnt` increments by 1 on each output handshake and wraps from 2^CNT_W−1 to 0.
- Reset, asynchronous and applicable at any time including mid-transfer: all `v` = 0, all data registers = 0, `done_cnt` = 0. In-flight beats are discarded.
- After reset release, `in_ready` = 1 on the first edge.

## Timing
- Latency: a beat accepted at edge n appears on `out_valid` after edge n+STAGES−1. That is, STAGES cycles from acceptance to visibility, with no stall.
- Throughput: 1 beat per cycle while `out_ready` = 1.
- Capacity: STAGES beats in flight. With `out_ready` = 0 and a continuous input, `in_ready` falls after exactly STAGES accepts.
- Simultaneous events when full:
  - Full pipeline with `out_ready` = 1 and `in_valid` = 1: one beat out and one beat in on the same edge, and occupancy is unchanged.
  - `out_ready` rising while full: `in_ready` rises in the same cycle, because it is combinational.
- Reset values while `rst_n` = 0: `in_ready` = 1, `out_valid` = 0, `e` = 0, `cout` = 0, `done_cnt` = 0.
- No combinational path from `in_valid`, `a` or `b` to any output.

## Structure
- Package `func_sel_pkg`:
  - op enum `OP_AND`=2'b00, `OP_OR`=2'b01, `OP_XOR`=2'b10, `OP_ADD`=2'b11.
  - the function `f_eval(op, a, b)`, returning `{cout,e}` at WIDTH+1 bits.
- Sub-module `func_sel_stage`: one valid/data/carry register with load/clear control. It is instantiated STAGES times by a generate loop.
- The top level holds the ready chain, the operation evaluation and `done_cnt`.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-stream with 2 beats in flight. Required: `out_valid` = 0, `done_cnt` = 0, `in_ready` = 1 immediately, and no stale beat appears after release.
- **Op sweep:** WIDTH = 8, `a` = 0xF0, `b` = 0x3C, ops 00/01/10/11. Required: `e` = 0x30, 0xFC, 0xCC, 0x2C, with `cout` = 0, 0, 0, 1 respectively.
- **Latency:** STAGES = 2, single beat accepted at edge n. Required: `out_valid` high after edge n+1, and `done_cnt` = 1 after the handshake.
- **Backpressure:** hold `out_ready` = 0 with `in_valid` held high. Required: exactly STAGES beats accepted, then `in_ready` = 0, and `e` stable. Release `out_ready`: all beats drain in order with no loss or duplicate.
- **Bubble collapse:** STAGES = 3, pattern one beat, one idle cycle, one beat, with `out_ready` = 0. Required: both beats held and `in_ready` = 1 for the third beat.
- **Counter wrap:** CNT_W = 4, 17 output handshakes. Required: `done_cnt` = 1.
